// File: rtl/vga_mode_sequencer_pkg.sv
// rtl/vga_mode_sequencer_pkg.sv - shared types, totals helpers and colour-bar LUT for the VGA mode sequencer
//
// Package vga_seq_pkg
//   seq_state_e    : sequencer state, S_RUN while modes remain, S_HOLD after the last mode
//   calc_h_total   : active + front porch + sync + back porch (horizontal)
//   calc_v_total   : same sum for the vertical direction
//   BAR_LUT        : {r,g,b} for the 8 vertical test bars, left to right

package vga_seq_pkg;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HOLD = 1'b1
    } seq_state_e;

    function automatic int calc_h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int calc_v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] BAR_LUT [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/vga_mode_sequencer_if.sv
// rtl/vga_mode_sequencer_if.sv - video output bundle between the sequencer and the DAC/framebuffer reader
//
// Signals: hsync, vsync (active low), de, x, y, r, g, b
// Modports: master (sequencer drives), slave (downstream samples)

interface vga_mode_sequencer_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           hsync;
    logic           vsync;
    logic           de;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [7:0]     r;
    logic [7:0]     g;
    logic [7:0]     b;

    modport master (output hsync, vsync, de, x, y, r, g, b);
    modport slave  (input  hsync, vsync, de, x, y, r, g, b);
endinterface

// File: rtl/vga_timing_core.sv
// rtl/vga_timing_core.sv - h/v position counters with registered sync and display-enable decode
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   pix_en        : pixel enable; counters and decode advance only when high
//   h_cnt_o       : current (pre-edge) horizontal position
//   v_cnt_o       : current (pre-edge) line
//   vis_o         : current position lies in the visible region
//   frame_end_o   : current position is the last pixel of the frame
//   hsync_o       : registered hsync for the position consumed at the last enabled edge
//   vsync_o       : registered vsync, same timing
//   de_o          : registered display enable, same timing

module vga_timing_core
    import vga_seq_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int X_W      = 10,
    parameter int Y_W      = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_en,
    output logic [X_W-1:0] h_cnt_o,
    output logic [Y_W-1:0] v_cnt_o,
    output logic           vis_o,
    output logic           frame_end_o,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           de_o
);

    localparam int H_TOTAL = calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [X_W-1:0] H_LAST       = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] H_VIS_END    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] H_SYNC_START = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] H_SYNC_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] V_LAST       = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] V_VIS_END    = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] V_SYNC_START = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] V_SYNC_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [X_W-1:0] h_cnt_q, h_cnt_d;
    logic [Y_W-1:0] v_cnt_q, v_cnt_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           de_q, de_d;
    logic           line_end;
    logic           vis;

    always_comb begin
        line_end = (h_cnt_q == H_LAST);
        vis      = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);

        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;

        if (pix_en) begin
            // Outputs reflect the position being left, so decode uses the pre-edge counters.
            hsync_d = !((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END));
            vsync_d = !((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END));
            de_d    = vis;
            if (line_end) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + Y_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
        end
    end

    assign h_cnt_o     = h_cnt_q;
    assign v_cnt_o     = v_cnt_q;
    assign vis_o       = vis;
    assign frame_end_o = line_end && (v_cnt_q == V_LAST);
    assign hsync_o     = hsync_q;
    assign vsync_o     = vsync_q;
    assign de_o        = de_q;

endmodule

// File: rtl/vga_mode_sequencer.sv
// rtl/vga_mode_sequencer.sv - VGA timing generator that steps through horizontal-resolution modes
//
// Mode m shows H_ACTIVE>>m image columns per line (each pixel repeated 2^m times),
// FRAMES_PER_MODE frames per mode, then holds the last mode with seq_done set.
// Optional macro VGA_PATTERN_EN: drive 8 vertical colour bars on r/g/b; otherwise r=g=b=0.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   pix_en      : pixel enable from the pixel-clock divider
//   restart     : request return to mode 0 at the next frame boundary
//   vga         : video bundle (hsync, vsync, de, x, y, r, g, b), master side
//   mode        : current mode index
//   frame_done  : one-clk pulse after the last pixel of each frame
//   seq_done    : sticky, all modes completed

module vga_mode_sequencer
    import vga_seq_pkg::*;
#(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int NUM_MODES       = 2,
    parameter int FRAMES_PER_MODE = 1,
    parameter int X_W             = 10,
    parameter int Y_W             = 10,
    localparam int MODE_W         = $clog2(NUM_MODES) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_en,
    input  logic                restart,
    vga_mode_sequencer_if.master vga,
    output logic [MODE_W-1:0]   mode,
    output logic                frame_done,
    output logic                seq_done
);

    localparam int FC_W = $clog2(FRAMES_PER_MODE) + 1;
    localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(FRAMES_PER_MODE - 1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

    logic [X_W-1:0] h_cnt;
    logic [Y_W-1:0] v_cnt;
    logic           vis;
    logic           frame_end;

    vga_timing_core #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .h_cnt_o     (h_cnt),
        .v_cnt_o     (v_cnt),
        .vis_o       (vis),
        .frame_end_o (frame_end),
        .hsync_o     (vga.hsync),
        .vsync_o     (vga.vsync),
        .de_o        (vga.de)
    );

    seq_state_e        state_q, state_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic              seq_done_q, seq_done_d;
    logic              restart_pend_q, restart_pend_d;
    logic              frame_done_q, frame_done_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic              boundary;
    logic              restart_req;

    always_comb begin
        boundary    = pix_en && frame_end;
        // A request arriving on the boundary edge itself still takes effect there.
        restart_req = restart_pend_q || restart;

        state_d        = state_q;
        mode_d         = mode_q;
        frame_cnt_d    = frame_cnt_q;
        seq_done_d     = seq_done_q;
        restart_pend_d = restart_req;
        frame_done_d   = boundary;
        x_d            = x_q;
        y_d            = y_q;

        if (pix_en) begin
            x_d = vis ? (h_cnt >> mode_q) : '0;
            y_d = vis ? v_cnt : '0;
        end

        if (boundary) begin
            if (restart_req) begin
                state_d        = S_RUN;
                mode_d         = '0;
                frame_cnt_d    = '0;
                seq_done_d     = 1'b0;
                restart_pend_d = 1'b0;
            end else if (state_q == S_RUN) begin
                if (frame_cnt_q == FC_LAST) begin
                    frame_cnt_d = '0;
                    if (mode_q < MODE_LAST) begin
                        mode_d = mode_q + MODE_W'(1);
                    end else begin
                        seq_done_d = 1'b1;
                        state_d    = S_HOLD;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q + FC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_RUN;
            mode_q         <= '0;
            frame_cnt_q    <= '0;
            seq_done_q     <= 1'b0;
            restart_pend_q <= 1'b0;
            frame_done_q   <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            frame_cnt_q    <= frame_cnt_d;
            seq_done_q     <= seq_done_d;
            restart_pend_q <= restart_pend_d;
            frame_done_q   <= frame_done_d;
            x_q            <= x_d;
            y_q            <= y_d;
        end
    end

`ifdef VGA_PATTERN_EN
    localparam logic [X_W-1:0] BAR_W = X_W'(H_ACTIVE / 8);

    logic [23:0] rgb_q, rgb_d;
    logic [2:0]  bar_idx;

    always_comb begin
        // Bars follow the raw h position, so they stay put across modes.
        bar_idx = 3'(h_cnt / BAR_W);
        rgb_d   = rgb_q;
        if (pix_en) begin
            rgb_d = vis ? BAR_LUT[bar_idx] : 24'h000000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= 24'h000000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign vga.r = rgb_q[23:16];
    assign vga.g = rgb_q[15:8];
    assign vga.b = rgb_q[7:0];
`else
    assign vga.r = 8'h00;
    assign vga.g = 8'h00;
    assign vga.b = 8'h00;
`endif

    assign vga.x      = x_q;
    assign vga.y      = y_q;
    assign mode       = mode_q;
    assign frame_done = frame_done_q;
    assign seq_done   = seq_done_q;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// tb/tb_vga_mode_sequencer.sv - directed self-checking bench for vga_mode_sequencer on a reduced raster

module tb_vga_mode_sequencer;

    localparam int H_ACT = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_ACT = 6, V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int NM = 2, FPM = 2, X_W = 10, Y_W = 10;
    localparam int HT = 24;
    localparam int FRAME = 240;

`ifdef VGA_PATTERN_EN
    localparam bit PAT = 1'b1;
`else
    localparam bit PAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_en;
    logic       restart;
    logic [1:0] mode;
    logic       frame_done;
    logic       seq_done;

    int checks = 0;
    int errors = 0;
    int t = 0;

    vga_mode_sequencer_if #(.X_W(X_W), .Y_W(Y_W)) vga_bus ();

    vga_mode_sequencer #(
        .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .NUM_MODES (NM), .FRAMES_PER_MODE (FPM), .X_W (X_W), .Y_W (Y_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .restart    (restart),
        .vga        (vga_bus),
        .mode       (mode),
        .frame_done (frame_done),
        .seq_done   (seq_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en);
        pix_en = en;
        @(posedge clk);
        #1;
        if (en) t++;
    endtask

    task automatic run_to(input int target);
        while (t < target) step(1'b1);
    endtask

    function automatic logic [31:0] rgb();
        return {8'h00, vga_bus.r, vga_bus.g, vga_bus.b};
    endfunction

    function automatic logic [31:0] exp_rgb(input logic [23:0] v);
        return PAT ? {8'h00, v} : 32'h0;
    endfunction

    function automatic logic [49:0] snapshot();
        return {vga_bus.hsync, vga_bus.vsync, vga_bus.de, vga_bus.x, vga_bus.y,
                vga_bus.r, vga_bus.g, vga_bus.b, mode, seq_done};
    endfunction

    initial begin
        logic [49:0] snap;
        int fall1, fall2, unstable, fs, b0;
        logic prev_hs;

        rst = 1'b1; pix_en = 1'b0; restart = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hsync", vga_bus.hsync, 1);
        chk("rst_vsync", vga_bus.vsync, 1);
        chk("rst_de", vga_bus.de, 0);
        chk("rst_x", vga_bus.x, 0);
        chk("rst_y", vga_bus.y, 0);
        chk("rst_mode", mode, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_sd", seq_done, 0);
        chk("rst_rgb", rgb(), 0);

        rst = 1'b0; t = 0;
        step(1'b1);
        chk("t1_de", vga_bus.de, 1);
        chk("t1_x", vga_bus.x, 0);
        chk("t1_y", vga_bus.y, 0);
        chk("t1_hsync", vga_bus.hsync, 1);
        chk("t1_vsync", vga_bus.vsync, 1);
        chk("t1_rgb", rgb(), exp_rgb(24'hFFFFFF));
        run_to(3);
        chk("h2_x", vga_bus.x, 2);
        chk("h2_rgb", rgb(), exp_rgb(24'hFFFF00));
        run_to(16);
        chk("h15_x", vga_bus.x, 15);
        chk("h15_de", vga_bus.de, 1);
        chk("h15_rgb", rgb(), exp_rgb(24'h000000));
        run_to(17);
        chk("h16_de", vga_bus.de, 0);
        chk("h16_x", vga_bus.x, 0);
        run_to(18); chk("h17_hsync", vga_bus.hsync, 1);
        run_to(19); chk("h18_hsync", vga_bus.hsync, 0);
        run_to(21); chk("h20_hsync", vga_bus.hsync, 0);
        run_to(22); chk("h21_hsync", vga_bus.hsync, 1);
        run_to(124);
        chk("v5h3_x", vga_bus.x, 3);
        chk("v5h3_y", vga_bus.y, 5);
        chk("v5h3_de", vga_bus.de, 1);
        run_to(145); chk("v6_vsync", vga_bus.vsync, 1);
        run_to(169);
        chk("v7_vsync", vga_bus.vsync, 0);
        chk("v7_de", vga_bus.de, 0);
        chk("v7_y", vga_bus.y, 0);
        run_to(216); chk("v8_vsync", vga_bus.vsync, 0);
        run_to(217); chk("v9_vsync", vga_bus.vsync, 1);
        run_to(239); chk("f1_fd_early", frame_done, 0);
        run_to(240);
        chk("f1_fd", frame_done, 1);
        chk("f1_mode", mode, 0);
        snap = snapshot();
        step(1'b0);
        chk("fd_drop_disabled", frame_done, 0);
        chk("frozen", 32'(snapshot() != snap), 0);
        run_to(241);
        chk("f2_de", vga_bus.de, 1);
        chk("f2_x", vga_bus.x, 0);
        run_to(480);
        chk("f2_fd", frame_done, 1);
        chk("f2_mode", mode, 1);
        run_to(483);
        chk("m1_h2_x", vga_bus.x, 1);
        chk("m1_h2_rgb", rgb(), exp_rgb(24'hFFFF00));
        run_to(496); chk("m1_h15_x", vga_bus.x, 7);
        run_to(720); chk("f3_mode", mode, 1);
        run_to(959); chk("sd_early", seq_done, 0);
        run_to(960);
        chk("sd_set", seq_done, 1);
        chk("sd_mode", mode, 1);
        run_to(1200);
        chk("hold_sd", seq_done, 1);
        chk("hold_mode", mode, 1);

        // pix_en on every second clock: hsync period doubles in clocks
        fall1 = -1; fall2 = -1; unstable = 0;
        prev_hs = vga_bus.hsync;
        for (int i = 0; i < 300 && fall2 < 0; i++) begin
            snap = snapshot();
            step((i % 2) == 0);
            if ((i % 2) != 0 && snapshot() != snap) unstable++;
            if (prev_hs && !vga_bus.hsync) begin
                if (fall1 < 0) fall1 = i;
                else fall2 = i;
            end
            prev_hs = vga_bus.hsync;
        end
        chk("hsync_period", 32'(fall2 - fall1), 48);
        chk("stable_disabled", 32'(unstable), 0);

        // restart requested mid-frame while holding, on a disabled clock
        fs = ((t / FRAME) + 1) * FRAME;
        run_to(fs + 3 * HT + 1);
        restart = 1'b1;
        step(1'b0);
        restart = 1'b0;
        chk("rs_sd_kept", seq_done, 1);
        run_to(fs + FRAME - 1);
        chk("rs_sd_pre", seq_done, 1);
        chk("rs_mode_pre", mode, 1);
        run_to(fs + FRAME);
        chk("rs_sd_clr", seq_done, 0);
        chk("rs_mode0", mode, 0);
        chk("rs_fd", frame_done, 1);
        b0 = fs + FRAME;
        run_to(b0 + FRAME);     chk("rs_f1_mode", mode, 0);
        run_to(b0 + 2 * FRAME); chk("rs_f2_mode", mode, 1);
        run_to(b0 + 4 * FRAME - 1);
        chk("co_sd_pre", seq_done, 0);
        restart = 1'b1;
        step(1'b1);
        restart = 1'b0;
        chk("co_sd", seq_done, 0);
        chk("co_mode", mode, 0);
        chk("co_fd", frame_done, 1);
        run_to(b0 + 5 * FRAME); chk("co_f1_mode", mode, 0);
        run_to(b0 + 6 * FRAME);
        chk("co_f2_mode", mode, 1);
        chk("co_f2_sd", seq_done, 0);

        // synchronous reset mid-frame at h=10, v=3
        run_to(b0 + 6 * FRAME + 3 * HT + 11);
        rst = 1'b1;
        step(1'b1);
        chk("mr_hsync", vga_bus.hsync, 1);
        chk("mr_vsync", vga_bus.vsync, 1);
        chk("mr_de", vga_bus.de, 0);
        chk("mr_x", vga_bus.x, 0);
        chk("mr_y", vga_bus.y, 0);
        chk("mr_mode", mode, 0);
        chk("mr_sd", seq_done, 0);
        chk("mr_rgb", rgb(), 0);
        rst = 1'b0; t = 0;
        step(1'b1);
        chk("mr_t1_de", vga_bus.de, 1);
        chk("mr_t1_x", vga_bus.x, 0);
        chk("mr_t1_y", vga_bus.y, 0);
        run_to(239); chk("mr_fd_early", frame_done, 0);
        run_to(240);
        chk("mr_fd", frame_done, 1);
        chk("mr_f1_mode", mode, 0);
        run_to(480); chk("mr_f2_mode", mode, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
